karatsuba_pipe: RTL and testbench

// - Pipelined, parametrised Karatsuba multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// - Splits operands into halves; forms 3 half-width products, not 4.
// - Per-transaction signed/unsigned mode and a passthrough tag.
// - Valid/ready streaming block for datapath and accelerator use; 1 result/cycle at full rate.

---
 rtl/karatsuba_pkg.sv | 11 +
 rtl/karatsuba_if.sv | 26 ++
 rtl/karatsuba_submul.sv | 18 +
 rtl/karatsuba_pipe.sv | 109 ++++++++++
 tb/tb_karatsuba_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/karatsuba_pkg.sv
// Shared constants and width helpers for the pipelined Karatsuba multiplier.
package karatsuba_pkg;

    localparam int unsigned KARA_LAT = 3;

    // Width of the middle product (xh+xl)*(yh+yl) for half-width h.
    function automatic int unsigned z1_width(input int unsigned h);
        return 2 * (h + 1);
    endfunction

endpackage

// File: rtl/karatsuba_if.sv
// Valid/ready operand and result streams of the Karatsuba multiplier.
interface karatsuba_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               signed_i;
    logic [TAG_W-1:0]   tag_i;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] c_o;
    logic [TAG_W-1:0]   tag_o;

    modport master (
        output in_valid, a_i, b_i, signed_i, tag_i, out_ready,
        input  in_ready, out_valid, c_o, tag_o
    );

    modport slave (
        input  in_valid, a_i, b_i, signed_i, tag_i, out_ready,
        output in_ready, out_valid, c_o, tag_o
    );
endinterface

// File: rtl/karatsuba_submul.sv
// Registered unsigned AW x AW multiply; holds its result while en is low.
module karatsuba_submul #(
    parameter int unsigned AW = 16
) (
    input  logic            clk,
    input  logic            en,
    input  logic [AW-1:0]   a,
    input  logic [AW-1:0]   b,
    output logic [2*AW-1:0] p
);
    localparam int unsigned PW = 2 * AW;

    always_ff @(posedge clk) begin
        if (en) begin
            p <= PW'(a) * PW'(b);
        end
    end
endmodule

// File: rtl/karatsuba_pipe.sv
// Three-stage Karatsuba multiplier: S1 sign/magnitude split, S2 three half products,
// S3 recombination and sign restore. A full output stalls every stage at once.
module karatsuba_pipe
    import karatsuba_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input logic        clk,
    input logic        rst,
    karatsuba_if.slave bus
);
    localparam int unsigned H   = WIDTH / 2;
    localparam int unsigned SW  = H + 1;
    localparam int unsigned Z1W = z1_width(H);
    localparam int unsigned PW  = 2 * WIDTH;

    logic             en;
    logic             out_valid_q;
    logic [PW-1:0]    c_q;
    logic [TAG_W-1:0] tag_q;

    assign en            = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.c_o       = c_q;
    assign bus.tag_o     = tag_q;

    // S1: sign and magnitudes; |-2^(W-1)| still fits in W unsigned bits.
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             in_sign;

    always_comb begin
        mag_a   = bus.a_i;
        mag_b   = bus.b_i;
        in_sign = 1'b0;
        if (bus.signed_i) begin
            if (bus.a_i[WIDTH-1]) mag_a = -bus.a_i;
            if (bus.b_i[WIDTH-1]) mag_b = -bus.b_i;
            in_sign = bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
        end
    end

    logic             s1_valid_q, s1_sign_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [H-1:0]     s1_xh_q, s1_xl_q, s1_yh_q, s1_yl_q;
    logic [SW-1:0]    s1_sx_q, s1_sy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (en) begin
            s1_valid_q <= bus.in_valid;
            s1_sign_q  <= in_sign;
            s1_tag_q   <= bus.tag_i;
            s1_xh_q    <= mag_a[WIDTH-1:H];
            s1_xl_q    <= mag_a[H-1:0];
            s1_yh_q    <= mag_b[WIDTH-1:H];
            s1_yl_q    <= mag_b[H-1:0];
            s1_sx_q    <= SW'(mag_a[WIDTH-1:H]) + SW'(mag_a[H-1:0]);
            s1_sy_q    <= SW'(mag_b[WIDTH-1:H]) + SW'(mag_b[H-1:0]);
        end
    end

    // S2: three half-width products instead of four.
    logic [2*H-1:0] z2, z0;
    logic [Z1W-1:0] z1;

    karatsuba_submul #(.AW(H))  u_z2 (.clk(clk), .en(en), .a(s1_xh_q), .b(s1_yh_q), .p(z2));
    karatsuba_submul #(.AW(H))  u_z0 (.clk(clk), .en(en), .a(s1_xl_q), .b(s1_yl_q), .p(z0));
    karatsuba_submul #(.AW(SW)) u_z1 (.clk(clk), .en(en), .a(s1_sx_q), .b(s1_sy_q), .p(z1));

    logic             s2_valid_q, s2_sign_q;
    logic [TAG_W-1:0] s2_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // S3: m = z1 - z2 - z0 is the cross term xh*yl + xl*yh, never negative.
    logic [Z1W-1:0] m;
    logic [PW-1:0]  p, res;

    always_comb begin
        m   = z1 - Z1W'(z2) - Z1W'(z0);
        p   = {z2, {WIDTH{1'b0}}} + (PW'(m) << H) + PW'(z0);
        res = s2_sign_q ? -p : p;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            tag_q       <= '0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                c_q   <= res;
                tag_q <= s2_tag_q;
            end
        end
    end
endmodule

// File: tb/tb_karatsuba_pipe.sv
// Directed and streaming checks of karatsuba_pipe at WIDTH=32, plus width sweeps at 8/16/64.
module tb_karatsuba_pipe;
    import karatsuba_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    typedef struct {
        logic [2*W-1:0] c;
        logic [TW-1:0]  tag;
    } exp_t;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        sw_rst     = 1'b1;
    logic        rand_ready = 1'b0;
    int unsigned tests      = 0;
    int unsigned fails      = 0;
    int unsigned rx_count   = 0;
    int unsigned rx_before  = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] st_c [3];

    always #5 clk = ~clk;

    karatsuba_if #(.WIDTH(W), .TAG_W(TW)) bus ();
    karatsuba_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic [2*W-1:0] ax, bx;
        ax = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        bx = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ax * bx;
    endfunction

    // Present one beat (caller sits just after a rising edge) and hold it until accepted.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [TW-1:0] t);
        logic hs;
        bit   ok;
        hs = 1'b0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.signed_i = s;
        bus.tag_i    = t;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) ok = 1'b1;
        end
        if (ok) exp_q.push_back('{c: ref_mul(a, b, s), tag: t});
        else check_eq("send_timeout", 128'(hs), 128'(1));
    endtask

    // Single beat into an idle pipe with out_ready high; checks exact latency and value.
    task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [TW-1:0] t, input logic [2*W-1:0] exp);
        bus.in_valid = 1'b1;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.signed_i = s;
        bus.tag_i    = t;
        exp_q.push_back('{c: exp, tag: t});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (KARA_LAT - 2) @(posedge clk);
        @(negedge clk);
        check_eq({name, "_early"}, 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        @(negedge clk);
        check_eq({name, "_valid"}, 128'(bus.out_valid), 128'(1));
        check_eq({name, "_c"}, 128'(bus.c_o), 128'(exp));
        check_eq({name, "_tag"}, 128'(bus.tag_o), 128'(t));
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #2;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("out_without_beat", 128'(bus.out_valid), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("stream_c", 128'(bus.c_o), 128'(mon_e.c));
                check_eq("stream_tag", 128'(bus.tag_o), 128'(mon_e.tag));
                rx_count++;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.signed_i  = 1'b0;
        bus.tag_i     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_c", 128'(bus.c_o), 128'(0));
        check_eq("rst_tag", 128'(bus.tag_o), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;

        run_one("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1, 64'hFFFF_FFFE_0000_0001);
        run_one("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 4'h2, 64'h4000_0000_0000_0000);
        run_one("s_m3x7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 4'h3, 64'hFFFF_FFFF_FFFF_FFEB);
        run_one("s_zero", 32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 4'h4, 64'h0);
        run_one("s_1xm1", 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 4'h5, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("u_1xmax", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 4'h6, 64'h0000_0000_FFFF_FFFF);
        run_one("s_maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'h7, 64'hC000_0000_8000_0000);
        run_one("u_2p16sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 4'h8, 64'h0000_0001_0000_0000);
        run_one("u_2p31sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 4'h9, 64'h4000_0000_0000_0000);

        // Random stream with a randomly throttled consumer.
        rx_before  = rx_count;
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send($urandom(), $urandom(), 1'($urandom_range(0, 1)), TW'(i));
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
        check_eq("stream_left", 128'(exp_q.size()), 128'(0));
        check_eq("stream_count", 128'(rx_count - rx_before), 128'(100));
        rand_ready = 1'b0;
        @(posedge clk);
        #3;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Stall with three beats in flight, then release.
        st_c[0] = 64'd30;
        st_c[1] = 64'd12;
        st_c[2] = 64'hFFFF_FFFF_FFFF_FFF0;
        send(32'd5, 32'd6, 1'b0, 4'h1);
        send(32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b1, 4'h2);
        send(32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 4'h3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_eq("stall_in_ready", 128'(bus.in_ready), 128'(0));
            check_eq("stall_valid", 128'(bus.out_valid), 128'(1));
            check_eq("stall_c", 128'(bus.c_o), 128'(st_c[0]));
            check_eq("stall_tag", 128'(bus.tag_o), 128'(1));
            @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq("drain_valid", 128'(bus.out_valid), 128'(1));
            check_eq("drain_c", 128'(bus.c_o), 128'(st_c[j]));
            check_eq("drain_tag", 128'(bus.tag_o), 128'(j + 1));
            @(posedge clk);
        end
        @(negedge clk);
        check_eq("drain_done", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;

        // Reset with two beats in flight: neither may ever come out.
        send(32'd7, 32'd9, 1'b0, 4'hA);
        send(32'd2, 32'd3, 1'b0, 4'hB);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_valid", 128'(bus.out_valid), 128'(0));
        check_eq("midrst_c", 128'(bus.c_o), 128'(0));
        check_eq("midrst_tag", 128'(bus.tag_o), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check_eq("midrst_ghost", 128'(bus.out_valid), 128'(0));
        end
        check_eq("midrst_in_ready", 128'(bus.in_ready), 128'(1));

        for (int k = 0; k < 20000 &&
             !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); k++) begin
            @(posedge clk);
        end
        check_eq("sweep_done",
                 128'({g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}), 128'(3'b111));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sw_rst = 1'b0;
    end

    // Width sweep: full-rate streams, boundary-heavy grid at 8 bits, random at 16 and 64.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned SW = (g == 0) ? 8 : ((g == 1) ? 16 : 64);

        typedef struct {
            logic [2*SW-1:0] c;
            logic [TW-1:0]   tag;
        } sexp_t;

        karatsuba_if #(.WIDTH(SW), .TAG_W(TW)) sbus ();
        karatsuba_pipe #(.WIDTH(SW), .TAG_W(TW)) u_dut (.clk(clk), .rst(sw_rst), .bus(sbus));

        sexp_t       q[$];
        sexp_t       e;
        logic        done = 1'b0;
        int unsigned sent = 0;
        int unsigned got  = 0;
        logic [63:0] r;

        function automatic logic [2*SW-1:0] sref(input logic [SW-1:0] a,
                                                 input logic [SW-1:0] b, input logic s);
            logic [2*SW-1:0] ax, bx;
            ax = s ? {{SW{a[SW-1]}}, a} : {{SW{1'b0}}, a};
            bx = s ? {{SW{b[SW-1]}}, b} : {{SW{1'b0}}, b};
            return ax * bx;
        endfunction

        function automatic logic [SW-1:0] bval(input int k);
            case (k)
                0:       return '0;
                1:       return SW'(1);
                2:       return {1'b0, {(SW-1){1'b1}}};
                3:       return {1'b1, {(SW-1){1'b0}}};
                4:       return {1'b1, {(SW-2){1'b0}}, 1'b1};
                5:       return '1;
                default: return SW'($urandom());
            endcase
        endfunction

        always @(negedge clk) begin
            if (!sw_rst && sbus.in_valid && sbus.in_ready) begin
                q.push_back('{c: sref(sbus.a_i, sbus.b_i, sbus.signed_i), tag: sbus.tag_i});
                sent++;
            end
            if (!sw_rst && sbus.out_valid && sbus.out_ready) begin
                if (q.size() == 0) begin
                    check_eq("sweep_extra", 128'(sbus.out_valid), 128'(0));
                end else begin
                    e = q.pop_front();
                    check_eq("sweep_c", 128'(sbus.c_o), 128'(e.c));
                    check_eq("sweep_tag", 128'(sbus.tag_o), 128'(e.tag));
                    got++;
                end
            end
        end

        initial begin
            sbus.in_valid  = 1'b0;
            sbus.a_i       = '0;
            sbus.b_i       = '0;
            sbus.signed_i  = 1'b0;
            sbus.tag_i     = '0;
            sbus.out_ready = 1'b1;
            wait (!sw_rst);
            @(posedge clk);
            #1;
            sbus.in_valid = 1'b1;
            if (SW == 8) begin
                for (int i = 0; i < 256; i++) begin
                    for (int k = 0; k < 8; k++) begin
                        for (int s = 0; s < 2; s++) begin
                            sbus.a_i      = SW'(i);
                            sbus.b_i      = bval(k);
                            sbus.signed_i = 1'(s);
                            sbus.tag_i    = TW'(i + k + s);
                            @(posedge clk);
                            #1;
                        end
                    end
                end
            end else begin
                for (int i = 0; i < 300; i++) begin
                    r             = {$urandom(), $urandom()};
                    sbus.a_i      = SW'(r);
                    r             = {$urandom(), $urandom()};
                    sbus.b_i      = SW'(r);
                    sbus.signed_i = 1'($urandom_range(0, 1));
                    sbus.tag_i    = TW'(i);
                    @(posedge clk);
                    #1;
                end
            end
            sbus.in_valid = 1'b0;
            for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
            @(negedge clk);
            check_eq("sweep_count", 128'(got), 128'(sent));
            done = 1'b1;
        end
    end
endmodule
